// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage for the RV32I/RV64I front end.
// Accepts {instruction, pc} over valid/ready and classifies the encoding format.
// Produces the sign-extended immediate, its type, an illegal flag and pc+imm.
// A one-deep skid register behind the output register keeps full throughput
// while in_ready stays a pure register output.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_imm_type,
  output logic             out_illegal,
  output logic [XLEN-1:0]  out_target,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    IMM_NONE    = 3'd0,
    IMM_I       = 3'd1,
    IMM_S       = 3'd2,
    IMM_B       = 3'd3,
    IMM_U       = 3'd4,
    IMM_J       = 3'd5,
    IMM_ILLEGAL = 3'd7
  } imm_type_e;

  // Everything one buffer slot holds; the target is precomputed at capture.
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic            illegal;
    logic [XLEN-1:0] target;
  } entry_t;

  imm_type_e       w_type;
  logic [XLEN-1:0] w_imm;
  entry_t          w_new;

  entry_t          r_out;
  entry_t          r_skid;
  logic            r_out_valid;
  logic            r_skid_valid;
  logic            r_in_ready;
  logic [CNT_W-1:0] r_cnt;

  logic w_accept;
  logic w_out_xfer;
  logic w_out_load;
  logic w_out_from_skid;
  logic w_skid_load;
  logic w_out_valid_nxt;
  logic w_skid_valid_nxt;

  // Classify the incoming opcode into its immediate format.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_type = IMM_ILLEGAL;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR,
        OPC_FENCE, OPC_SYSTEM:        w_type = IMM_I;
        OPC_OP_IMM_32:                w_type = IS_RV64 ? IMM_I : IMM_ILLEGAL;
        OPC_STORE:                    w_type = IMM_S;
        OPC_BRANCH:                   w_type = IMM_B;
        OPC_LUI, OPC_AUIPC:           w_type = IMM_U;
        OPC_JAL:                      w_type = IMM_J;
        OPC_OP:                       w_type = IMM_NONE;
        OPC_OP_32:                    w_type = IS_RV64 ? IMM_NONE : IMM_ILLEGAL;
        default:                      w_type = IMM_ILLEGAL;
      endcase
    end
  end

  // Assemble the immediate; sign bit is always instr[31], extended by a signed size cast.
  always_comb begin
    w_imm = '0;
    case (w_type)
      IMM_I: w_imm = XLEN'($signed(in_instr[31:20]));
      IMM_S: w_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      IMM_B: w_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                    in_instr[11:8], 1'b0}));
      IMM_U: w_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      IMM_J: w_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                    in_instr[30:21], 1'b0}));
      default: w_imm = '0;
    endcase
  end

  // Pack the freshly decoded instruction into a buffer entry.
  always_comb begin
    w_new          = '0;
    w_new.instr    = in_instr;
    w_new.pc       = in_pc;
    w_new.imm      = w_imm;
    w_new.imm_type = w_type;
    w_new.illegal  = (w_type == IMM_ILLEGAL);
    w_new.target   = in_pc + w_imm;
  end

  // Steering: the output register refills when empty or draining, otherwise new data parks in the skid.
  // in_ready is low whenever the skid is full, so an accept never coincides with a skid-to-out move.
  always_comb begin
    w_accept         = in_valid & r_in_ready;
    w_out_xfer       = r_out_valid & out_ready;
    w_out_load       = ~r_out_valid | w_out_xfer;
    w_out_from_skid  = w_out_load & r_skid_valid;
    w_skid_load      = w_accept & ~w_out_load;
    w_out_valid_nxt  = w_out_load ? (r_skid_valid | w_accept) : 1'b1;
    w_skid_valid_nxt = w_skid_load ? 1'b1 : (w_out_from_skid ? 1'b0 : r_skid_valid);
  end

  // Occupancy flags and the registered in_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_out_valid  <= w_out_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  // Output register payload: loads from the skid first to keep program order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset too, because every output must read 0 out of reset.
      r_out <= '0;
    end else if (w_out_from_skid) begin
      r_out <= r_skid;
    end else if (w_out_load && w_accept) begin
      r_out <= w_new;
    end
  end

  // Skid register payload: captures an accept while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid <= '0;
    end else if (w_skid_load) begin
      r_skid <= w_new;
    end
  end

  // Saturating count of illegal instructions handed downstream; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_out_xfer && r_out.illegal && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_instr    = r_out.instr;
  assign out_pc       = r_out.pc;
  assign out_imm      = r_out.imm;
  assign out_imm_type = r_out.imm_type;
  assign out_illegal  = r_out.illegal;
  assign out_target   = r_out.target;
  assign illegal_cnt  = r_cnt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: an RV32 build with a 2-bit counter and an RV64 build
// share one input stream; a scoreboard queue holds the expected decode of each
// accepted instruction and a monitor compares it against both builds on delivery.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc32;
  logic [63:0] in_pc64;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_instr32, out_pc32, out_imm32, out_target32;
  logic [2:0]  out_type32;
  logic [1:0]  cnt32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64;
  logic [63:0] out_pc64, out_imm64, out_target64;
  logic [2:0]  out_type64;
  logic [15:0] cnt64;

  assign in_pc64 = {32'h0, in_pc32};

  imm_decode_stage #(.XLEN(32), .CNT_W(2)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready), .out_instr(out_instr32),
    .out_pc(out_pc32), .out_imm(out_imm32), .out_imm_type(out_type32),
    .out_illegal(out_illegal32), .out_target(out_target32),
    .cnt_clr(cnt_clr), .illegal_cnt(cnt32)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64),
    .out_pc(out_pc64), .out_imm(out_imm64), .out_imm_type(out_type64),
    .out_illegal(out_illegal64), .out_target(out_target64),
    .cnt_clr(cnt_clr), .illegal_cnt(cnt64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm32;
    logic [2:0]  ty32;
    logic [63:0] imm64;
    logic [2:0]  ty64;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;

  // Delivery monitor: a transfer happens at the next rising edge when valid & ready hold now.
  always @(negedge clk) begin
    if (rst_n && out_valid32 && out_ready) begin
      checks += 1;
      if (sb_q.size() == 0) begin
        errors += 1;
        $display("FAIL unexpected_delivery instr=%h (scoreboard empty)", out_instr32);
      end else begin
        m_e = sb_q.pop_front();
        if (out_instr32 !== m_e.instr || out_pc32 !== m_e.pc || out_imm32 !== m_e.imm32 ||
            out_type32 !== m_e.ty32 || out_illegal32 !== (m_e.ty32 == 3'd7) ||
            out_target32 !== m_e.pc + m_e.imm32) begin
          errors += 1;
          $display("FAIL rv32_out got instr=%h pc=%h imm=%h type=%0d ill=%b tgt=%h want instr=%h pc=%h imm=%h type=%0d tgt=%h",
                   out_instr32, out_pc32, out_imm32, out_type32, out_illegal32, out_target32,
                   m_e.instr, m_e.pc, m_e.imm32, m_e.ty32, m_e.pc + m_e.imm32);
        end
        checks += 1;
        if (out_valid64 !== 1'b1 || out_instr64 !== m_e.instr || out_pc64 !== {32'h0, m_e.pc} ||
            out_imm64 !== m_e.imm64 || out_type64 !== m_e.ty64 ||
            out_illegal64 !== (m_e.ty64 == 3'd7) ||
            out_target64 !== {32'h0, m_e.pc} + m_e.imm64) begin
          errors += 1;
          $display("FAIL rv64_out got v=%b instr=%h imm=%h type=%0d ill=%b tgt=%h want instr=%h imm=%h type=%0d tgt=%h",
                   out_valid64, out_instr64, out_imm64, out_type64, out_illegal64, out_target64,
                   m_e.instr, m_e.imm64, m_e.ty64, {32'h0, m_e.pc} + m_e.imm64);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Present one instruction and hold it until accepted; called and returns at posedge+1.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] imm32, input logic [2:0] ty32,
                      input logic [63:0] imm64, input logic [2:0] ty64);
    exp_t e;
    int   n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc32  = pc;
    @(negedge clk);
    while (!in_ready32 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks += 1;
    if (!in_ready32) begin
      errors += 1;
      $display("FAIL send_timeout instr=%h in_ready=%b want 1", instr, in_ready32);
    end else begin
      e.instr = instr; e.pc = pc; e.imm32 = imm32; e.ty32 = ty32;
      e.imm64 = imm64; e.ty64 = ty64;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Stop driving and let everything pending reach the output.
  task automatic drain();
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb_q.size() != 0 || out_valid32) && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    checks += 1;
    if (sb_q.size() != 0 || out_valid32 !== 1'b0) begin
      errors += 1;
      $display("FAIL drain pending=%0d out_valid=%b want 0 and 0", sb_q.size(), out_valid32);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc32 = '0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 1;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_imm32 !== '0 || out_type32 !== 3'd0 ||
        out_illegal32 !== 1'b0 || out_target32 !== '0 || out_instr32 !== '0 || cnt32 !== '0) begin
      errors += 1;
      $display("FAIL reset_rv32 v=%b rdy=%b imm=%h type=%0d ill=%b cnt=%0d want 0 1 0 0 0 0",
               out_valid32, in_ready32, out_imm32, out_type32, out_illegal32, cnt32);
    end
    checks += 1;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_imm64 !== '0 || out_pc64 !== '0 ||
        cnt64 !== '0) begin
      errors += 1;
      $display("FAIL reset_rv64 v=%b rdy=%b imm=%h cnt=%0d want 0 1 0 0",
               out_valid64, in_ready64, out_imm64, cnt64);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send(32'h00A02503, 32'h100, 32'h0000000A, 3'd1, 64'hA, 3'd1);
    in_valid = 1'b0;
    checks += 1;
    if (out_valid32 !== 1'b1 || out_imm32 !== 32'h0000000A || out_type32 !== 3'd1 ||
        out_target32 !== 32'h0000010A) begin
      errors += 1;
      $display("FAIL lw_latency v=%b imm=%h type=%0d tgt=%h want 1 0000000a 1 0000010a",
               out_valid32, out_imm32, out_type32, out_target32);
    end
    drain();
    send(32'hFE550CE3, 32'h1000, 32'hFFFFFFF8, 3'd3, 64'hFFFFFFFF_FFFFFFF8, 3'd3);
    in_valid = 1'b0;
    checks += 1;
    if (out_valid32 !== 1'b1 || out_imm32 !== 32'hFFFFFFF8 || out_type32 !== 3'd3 ||
        out_target32 !== 32'h00000FF8) begin
      errors += 1;
      $display("FAIL beq_latency v=%b imm=%h type=%0d tgt=%h want 1 fffffff8 3 00000ff8",
               out_valid32, out_imm32, out_type32, out_target32);
    end
    drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h12345637, 32'h200, 32'h12345000, 3'd4, 64'h12345000, 3'd4);
    send(32'h004000EF, 32'h204, 32'h00000004, 3'd5, 64'h4, 3'd5);
    in_valid = 1'b1; in_instr = 32'h01400513; in_pc32 = 32'h208;
    for (int i = 0; i < 3; i++) begin
      checks += 1;
      if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || out_instr32 !== 32'h12345637 ||
          out_imm32 !== 32'h12345000 || out_pc32 !== 32'h200) begin
        errors += 1;
        $display("FAIL stall_hold cyc=%0d rdy=%b v=%b instr=%h imm=%h want 0 1 12345637 12345000",
                 i, in_ready32, out_valid32, out_instr32, out_imm32);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h01400513, 32'h208, 32'h00000014, 3'd1, 64'h14, 3'd1);
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send(32'hFFDFF0EF, 32'h0, 32'hFFFFFFFC, 3'd5, 64'hFFFFFFFF_FFFFFFFC, 3'd5);
    send(32'h01400513, 32'hFFFFFFF0, 32'h14, 3'd1, 64'h14, 3'd1);
    send(32'h00A02423, 32'h300, 32'h8, 3'd2, 64'h8, 3'd2);
    send(32'h00B50533, 32'h304, 32'h0, 3'd0, 64'h0, 3'd0);
    send(32'h00001517, 32'h308, 32'h1000, 3'd4, 64'h1000, 3'd4);
    send(32'h00A02501, 32'h30C, 32'h0, 3'd7, 64'h0, 3'd7);
    send(32'h0000003B, 32'h310, 32'h0, 3'd7, 64'h0, 3'd0);
    drain();
  endtask

  task automatic test_rv64();
    out_ready = 1'b1;
    send(32'hFFFFF637, 32'h400, 32'hFFFFF000, 3'd4, 64'hFFFFFFFF_FFFFF000, 3'd4);
    send(32'h0010051B, 32'h404, 32'h0, 3'd7, 64'h1, 3'd1);
    drain();
  endtask

  task automatic test_illegal_counter();
    logic [1:0]  want32;
    logic [15:0] want64;
    out_ready = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(32'h0, 32'h500 + 32'(i * 4), 32'h0, 3'd7, 64'h0, 3'd7);
      in_valid = 1'b0;
      @(posedge clk); #1;
      want32 = (i >= 2) ? 2'd3 : 2'(i + 1);
      want64 = 16'(i + 1);
      checks += 1;
      if (cnt32 !== want32 || cnt64 !== want64) begin
        errors += 1;
        $display("FAIL illegal_cnt step=%0d got %0d/%0d want %0d/%0d",
                 i, cnt32, cnt64, want32, want64);
      end
    end
    out_ready = 1'b0;
    send(32'h0, 32'h600, 32'h0, 3'd7, 64'h0, 3'd7);
    in_valid = 1'b0;
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    checks += 1;
    if (cnt32 !== 2'd0 || cnt64 !== 16'd0) begin
      errors += 1;
      $display("FAIL cnt_clr_priority got %0d/%0d want 0/0", cnt32, cnt64);
    end
    send(32'hFFFFFFFF, 32'h604, 32'h0, 3'd7, 64'h0, 3'd7);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks += 1;
    if (cnt32 !== 2'd1 || cnt64 !== 16'd1) begin
      errors += 1;
      $display("FAIL cnt_after_clr got %0d/%0d want 1/1", cnt32, cnt64);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    send(32'h00100093, 32'h700, 32'h1, 3'd1, 64'h1, 3'd1);
    send(32'h00200113, 32'h704, 32'h2, 3'd1, 64'h2, 3'd1);
    in_valid = 1'b0;
    @(posedge clk); #2;
    checks += 1;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1) begin
      errors += 1;
      $display("FAIL both_full rdy=%b v=%b want 0 1", in_ready32, out_valid32);
    end
    rst_n = 1'b0;
    #1;
    checks += 1;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      errors += 1;
      $display("FAIL async_reset v=%b rdy=%b v64=%b rdy64=%b want 0 1 0 1",
               out_valid32, in_ready32, out_valid64, in_ready64);
    end
    sb_q.delete();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00300193, 32'h800, 32'h3, 3'd1, 64'h3, 3'd1);
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_backpressure();
    test_back_to_back();
    test_rv64();
    test_illegal_counter();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
